// File: rtl/message_scheduler.sv
// message_scheduler
// -----------------------------------------------------------------------------
// SHA-256 message schedule generator. Accepts one 512-bit padded block and
// streams W[0..ROUNDS-1] one word per accepted transfer, using a 16-word
// sliding window so that W[16..] is produced on the fly.
//
// Optional feature macro: SCHED_BYTE_SWAP_EN
//   defined   - every 32-bit word of block_in is byte-reversed at load
//               (little-endian upstream buffers).
//   undefined - words load as-is (big-endian, SHA-256 native).
//
// Parameters:
//   WORD_SIZE   schedule word width; must be 32 (SHA-256 sigma constants)
//   ROUNDS      words streamed per block, 17..64
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   clear        synchronous abort back to IDLE (window contents kept)
//   block_in     padded block; [511:480] is W[0], [31:0] is W[15]
//   block_valid  block_in is valid
//   block_ready  a new block can be accepted (IDLE only)
//   input_ready  one-cycle start pulse to the round engine
//   w_value      current schedule word W[t]
//   w_index      current t
//   w_valid      w_value/w_index are valid
//   w_ready      consumer accepts the current word
//   block_done   one-cycle pulse after W[ROUNDS-1] is accepted
// -----------------------------------------------------------------------------
module message_scheduler #(
  parameter int WORD_SIZE = 32,
  parameter int ROUNDS    = 64,
  localparam int IDX_W    = $clog2(ROUNDS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic [WORD_SIZE*16-1:0]   block_in,
  input  logic                      block_valid,
  output logic                      block_ready,
  output logic                      input_ready,
  output logic [WORD_SIZE-1:0]      w_value,
  output logic [IDX_W-1:0]          w_index,
  output logic                      w_valid,
  input  logic                      w_ready,
  output logic                      block_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(ROUNDS - 1);

  state_t               state;
  state_t               state_next;
  logic                 load;
  logic                 advance;
  logic [IDX_W-1:0]     t;
  logic [WORD_SIZE-1:0] window [16];
  logic [WORD_SIZE-1:0] new_word;

  function automatic logic [WORD_SIZE-1:0] sigma0(input logic [WORD_SIZE-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [WORD_SIZE-1:0] sigma1(input logic [WORD_SIZE-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  function automatic logic [WORD_SIZE-1:0] load_word(input logic [WORD_SIZE-1:0] x);
`ifdef SCHED_BYTE_SWAP_EN
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
    return x;
`endif
  endfunction

  // Next word enters at the top of the window: W[t+16] from W[t+14], W[t+9],
  // W[t+1] and W[t], all of which sit at fixed window positions.
  assign new_word = sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0];

  assign w_value    = window[0];
  assign w_index    = t;
  assign w_valid    = (state == ST_RUN);
  assign block_done = (state == ST_DONE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    advance    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (block_valid && block_ready) begin
          load       = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_ready) begin
          advance = 1'b1;
          if (t == LAST) begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    // clear overrides every other input in the same cycle
    if (clear) begin
      state_next = ST_IDLE;
      load       = 1'b0;
      advance    = 1'b0;
    end
  end

  // block_ready is registered from the next state so it stays low while
  // reset is held and rises on the first clock after release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 16; i++) begin
        window[i] <= '0;
      end
      t           <= '0;
      block_ready <= 1'b0;
      input_ready <= 1'b0;
    end else begin
      block_ready <= (state_next == ST_IDLE);
      input_ready <= load;

      if (clear || load) begin
        t <= '0;
      end else if (advance && (t != LAST)) begin
        t <= t + IDX_W'(1);
      end

      if (load) begin
        for (int unsigned i = 0; i < 16; i++) begin
          window[i] <= load_word(block_in[(15 - i) * WORD_SIZE +: WORD_SIZE]);
        end
      end else if (advance) begin
        for (int unsigned i = 0; i < 15; i++) begin
          window[i] <= window[i + 1];
        end
        window[15] <= new_word;
      end
    end
  end

endmodule

// File: tb/tb_message_scheduler.sv
// tb_message_scheduler
// Directed bench for message_scheduler: reset state, "abc" block schedule,
// stalls, clear, mid-block reset, back-to-back blocks and (when built with
// SCHED_BYTE_SWAP_EN) byte-reversed loading.
module tb_message_scheduler;

  localparam int ROUNDS = 64;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         clear = 1'b0;
  logic [511:0] block_in = '0;
  logic         block_valid = 1'b0;
  logic         block_ready;
  logic         input_ready;
  logic [31:0]  w_value;
  logic [5:0]   w_index;
  logic         w_valid;
  logic         w_ready = 1'b0;
  logic         block_done;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_w [ROUNDS];
  logic [31:0] got_w [ROUNDS];

  localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};

  message_scheduler #(.WORD_SIZE(32), .ROUNDS(ROUNDS)) dut (
    .clock       (clock),
    .reset       (reset),
    .clear       (clear),
    .block_in    (block_in),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .input_ready (input_ready),
    .w_value     (w_value),
    .w_index     (w_index),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .block_done  (block_done)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
  endfunction

  // Reference schedule in the textbook form W[t] = f(W[t-2],W[t-7],W[t-15],W[t-16]).
  task automatic build_model(input logic [511:0] blk);
    for (int i = 0; i < 16; i++) exp_w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < ROUNDS; i++)
      exp_w[i] = ref_s1(exp_w[i-2]) + exp_w[i-7] + ref_s0(exp_w[i-15]) + exp_w[i-16];
  endtask

  // Native block -> what the DUT input must carry for this build.
  function automatic logic [511:0] to_dut(input logic [511:0] blk);
    logic [511:0] r;
    r = blk;
`ifdef SCHED_BYTE_SWAP_EN
    for (int i = 0; i < 16; i++) begin
      r[32*i +: 32] = {blk[32*i +: 8], blk[32*i+8 +: 8], blk[32*i+16 +: 8], blk[32*i+24 +: 8]};
    end
`endif
    return r;
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic send_block(input logic [511:0] dut_blk);
    int guard;
    guard = 0;
    while (block_ready !== 1'b1 && guard < 200) begin
      tick;
      guard++;
    end
    checks++;
    if (block_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready_timeout: block_ready=%b want 1", block_ready);
    end
    block_in    = dut_blk;
    block_valid = 1'b1;
    tick;
    block_valid = 1'b0;
    checks++;
    if (input_ready !== 1'b1) begin
      failures++;
      $display("FAIL start_pulse: input_ready=%b want 1", input_ready);
    end
    checks++;
    if (w_valid !== 1'b1 || w_index !== 6'd0) begin
      failures++;
      $display("FAIL first_word: w_valid=%b w_index=%0d want 1/0", w_valid, w_index);
    end
    checks++;
    if (block_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_in_run: block_ready=%b want 0", block_ready);
    end
  endtask

  // Streams a whole block with w_ready=1, checking every word against exp_w.
  // Cycle numbering: acceptance cycle is 1, so DONE is cycle ROUNDS+2.
  task automatic run_block(input logic [511:0] dut_blk);
    int cyc;
    int words;
    w_ready = 1'b1;
    send_block(dut_blk);
    cyc   = 2;
    words = 0;
    while (block_done !== 1'b1 && cyc < 200) begin
      if (w_valid === 1'b1) begin
        if (words < ROUNDS) begin
          checks++;
          if (w_index !== 6'(words)) begin
            failures++;
            $display("FAIL w_index: got %0d want %0d", w_index, words);
          end
          checks++;
          if (w_value !== exp_w[words]) begin
            failures++;
            $display("FAIL w_value[%0d]: got %08h want %08h", words, w_value, exp_w[words]);
          end
          got_w[words] = w_value;
        end
        words++;
      end
      tick;
      cyc++;
    end
    checks++;
    if (cyc !== 66) begin
      failures++;
      $display("FAIL done_latency: block_done in cycle %0d want 66", cyc);
    end
    checks++;
    if (words !== ROUNDS) begin
      failures++;
      $display("FAIL word_count: got %0d want %0d", words, ROUNDS);
    end
    checks++;
    if (w_valid !== 1'b0) begin
      failures++;
      $display("FAIL valid_in_done: w_valid=%b want 0", w_valid);
    end
    tick;
    checks++;
    if (block_done !== 1'b0 || block_ready !== 1'b1) begin
      failures++;
      $display("FAIL after_done: block_done=%b block_ready=%b want 0/1", block_done, block_ready);
    end
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({block_ready, input_ready, w_valid, block_done} !== 4'b0 || w_value !== 32'h0 || w_index !== 6'd0) begin
      failures++;
      $display("FAIL reset_outputs: rdy=%b ir=%b v=%b done=%b val=%08h idx=%0d want all 0",
               block_ready, input_ready, w_valid, block_done, w_value, w_index);
    end
    tick;
    checks++;
    if (block_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_during_reset: block_ready=%b want 0", block_ready);
    end
    #2 reset = 1'b1;
    tick;
    checks++;
    if (block_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset: block_ready=%b want 1", block_ready);
    end
  endtask

  task automatic test_abc;
    int spot_idx [4];
    logic [31:0] spot_val [4];
    spot_idx = '{16, 17, 18, 63};
    spot_val = '{32'h61626380, 32'h000F0000, 32'h7DA86405, 32'h12B1EDEB};
    build_model(ABC);
    run_block(to_dut(ABC));
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_w[spot_idx[i]] !== spot_val[i]) begin
        failures++;
        $display("FAIL abc_W%0d: got %08h want %08h", spot_idx[i], got_w[spot_idx[i]], spot_val[i]);
      end
    end
  endtask

  task automatic test_stall;
    int acc;
    int guard;
    logic r;
    logic v;
    build_model(ABC);
    w_ready = 1'b0;
    send_block(to_dut(ABC));
    acc = 0; guard = 0; r = 1'b0;
    while (block_done !== 1'b1 && guard < 400) begin
      if (w_valid === 1'b1 && acc < ROUNDS) begin
        checks++;
        if (w_index !== 6'(acc)) begin
          failures++;
          $display("FAIL stall_index: got %0d want %0d", w_index, acc);
        end
        checks++;
        if (w_value !== exp_w[acc]) begin
          failures++;
          $display("FAIL stall_value[%0d]: got %08h want %08h", acc, w_value, exp_w[acc]);
        end
      end
      v = w_valid;
      r = ~r;
      w_ready = r;
      tick;
      if (v === 1'b1 && r) acc++;
      guard++;
    end
    checks++;
    if (acc !== ROUNDS || block_done !== 1'b1) begin
      failures++;
      $display("FAIL stall_count: accepted %0d done=%b want %0d/1", acc, block_done, ROUNDS);
    end
    w_ready = 1'b1;
    tick;
  endtask

  task automatic test_clear;
    logic [511:0] b2;
    build_model(ABC);
    w_ready = 1'b1;
    send_block(to_dut(ABC));
    repeat (20) tick;
    checks++;
    if (w_index !== 6'd20 || w_value !== exp_w[20]) begin
      failures++;
      $display("FAIL clear_pre: idx=%0d val=%08h want 20/%08h", w_index, w_value, exp_w[20]);
    end
    clear = 1'b1;
    tick;
    clear = 1'b0;
    checks++;
    if ({w_valid, input_ready, block_done, block_ready} !== 4'b0001 || w_index !== 6'd0) begin
      failures++;
      $display("FAIL clear_effect: v=%b ir=%b done=%b rdy=%b idx=%0d want 0/0/0/1/0",
               w_valid, input_ready, block_done, block_ready, w_index);
    end
    // clear wins over a simultaneous valid block in IDLE
    clear = 1'b1;
    block_in = to_dut(ABC);
    block_valid = 1'b1;
    tick;
    clear = 1'b0;
    block_valid = 1'b0;
    checks++;
    if (input_ready !== 1'b0 || w_valid !== 1'b0 || block_ready !== 1'b1) begin
      failures++;
      $display("FAIL clear_priority: ir=%b v=%b rdy=%b want 0/0/1", input_ready, w_valid, block_ready);
    end
    for (int i = 0; i < 16; i++) b2[511 - 32*i -: 32] = 32'h9E3779B9 * (i + 1) ^ 32'h0F0F1234;
    build_model(b2);
    run_block(to_dut(b2));
  endtask

  task automatic test_reset_mid;
    int seen_v;
    int seen_d;
    build_model(ABC);
    w_ready = 1'b1;
    send_block(to_dut(ABC));
    repeat (40) tick;
    checks++;
    if (w_index !== 6'd40) begin
      failures++;
      $display("FAIL reset_mid_pre: idx=%0d want 40", w_index);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({block_ready, input_ready, w_valid, block_done} !== 4'b0 || w_value !== 32'h0 || w_index !== 6'd0) begin
      failures++;
      $display("FAIL reset_async: rdy=%b ir=%b v=%b done=%b val=%08h idx=%0d want all 0",
               block_ready, input_ready, w_valid, block_done, w_value, w_index);
    end
    tick;
    #2 reset = 1'b1;
    tick;
    seen_v = 0; seen_d = 0;
    for (int i = 0; i < 80; i++) begin
      if (w_valid === 1'b1) seen_v++;
      if (block_done === 1'b1) seen_d++;
      tick;
    end
    checks++;
    if (seen_v !== 0 || seen_d !== 0) begin
      failures++;
      $display("FAIL reset_no_tail: w_valid cycles=%0d done cycles=%0d want 0/0", seen_v, seen_d);
    end
    checks++;
    if (block_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_ready: block_ready=%b want 1", block_ready);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, ir_cnt, dn, idx, words, first_ir;
    logic prev_ir;
    build_model(ABC);
    w_ready = 1'b1;
    block_in = to_dut(ABC);
    block_valid = 1'b1;
    cyc = 0; ir_cnt = 0; dn = 0; idx = 0; words = 0; first_ir = 0; prev_ir = 1'b0;
    while (cyc < 400) begin
      if (input_ready === 1'b1) begin
        ir_cnt++;
        checks++;
        if (prev_ir !== 1'b0) begin
          failures++;
          $display("FAIL ir_width: input_ready high two cycles");
        end
        if (ir_cnt == 1) first_ir = cyc;
        if (ir_cnt == 2) begin
          checks++;
          if (cyc - first_ir !== 66) begin
            failures++;
            $display("FAIL b2b_period: got %0d cycles want 66", cyc - first_ir);
          end
        end
        idx = 0;
      end
      if (w_valid === 1'b1) begin
        checks++;
        if (block_ready !== 1'b0) begin
          failures++;
          $display("FAIL b2b_ready_in_run: block_ready=%b want 0", block_ready);
        end
        if (idx < ROUNDS) begin
          checks++;
          if (w_value !== exp_w[idx]) begin
            failures++;
            $display("FAIL b2b_value[%0d]: got %08h want %08h", idx, w_value, exp_w[idx]);
          end
        end
        idx++;
        words++;
      end
      if (block_done === 1'b1) begin
        dn++;
        if (dn == 2) begin
          block_valid = 1'b0;
          break;
        end
      end
      prev_ir = input_ready;
      tick;
      cyc++;
    end
    checks++;
    if (ir_cnt !== 2 || dn !== 2 || words !== 2*ROUNDS) begin
      failures++;
      $display("FAIL b2b_counts: starts=%0d dones=%0d words=%0d want 2/2/%0d", ir_cnt, dn, words, 2*ROUNDS);
    end
    tick;
    tick;
    checks++;
    if (input_ready !== 1'b0 || w_valid !== 1'b0 || block_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_idle: ir=%b v=%b rdy=%b want 0/0/1", input_ready, w_valid, block_ready);
    end
  endtask

`ifdef SCHED_BYTE_SWAP_EN
  task automatic test_byte_swap;
    logic [511:0] raw;
    raw = {32'h80636261, 448'h0, 32'h18000000};
    build_model(ABC);
    run_block(raw);
    checks++;
    if (got_w[0] !== 32'h61626380 || got_w[15] !== 32'h00000018) begin
      failures++;
      $display("FAIL swap_load: W0=%08h W15=%08h want 61626380/00000018", got_w[0], got_w[15]);
    end
    checks++;
    if (got_w[63] !== 32'h12B1EDEB) begin
      failures++;
      $display("FAIL swap_W63: got %08h want 12b1edeb", got_w[63]);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_abc;
    test_stall;
    test_clear;
    test_reset_mid;
    test_back_to_back;
`ifdef SCHED_BYTE_SWAP_EN
    test_byte_swap;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
